// File: rtl/trigger_ctrl_pkg.sv
// Shared definitions for the acquisition/trigger controller: state encoding,
// edge-select constants and default widths.
package trigger_ctrl_pkg;

  localparam int BITS_ADC_DEF   = 8;
  localparam int BITS_COUNT_DEF = 16;

  typedef enum logic [1:0] {
    TRIG_ST_IDLE = 2'd0,
    TRIG_ST_PRE  = 2'd1,
    TRIG_ST_WAIT = 2'd2,
    TRIG_ST_POST = 2'd3
  } trig_state_t;

  localparam logic TRIG_EDGE_RISING  = 1'b0;
  localparam logic TRIG_EDGE_FALLING = 1'b1;

endpackage

// File: rtl/trigger_ctrl_edge_detect.sv
// Combinational level-crossing detector. A crossing needs a valid previous
// sample, so the first sample of an acquisition can never produce a hit.
module edge_detect
  import trigger_ctrl_pkg::*;
#(
  parameter int W = BITS_ADC_DEF
) (
  input  logic [W-1:0] prev,
  input  logic         prev_valid,
  input  logic [W-1:0] cur,
  input  logic [W-1:0] level,
  input  logic         falling,
  output logic         hit
);

  // Rising: prev below level and cur at or above it; falling is the mirror.
  always_comb begin
    hit = 1'b0;
    if (prev_valid) begin
      if (falling == TRIG_EDGE_FALLING) begin
        hit = (prev > level) && (cur <= level);
      end else begin
        hit = (prev < level) && (cur >= level);
      end
    end
  end

endmodule

// File: rtl/trigger_ctrl.sv
// Acquisition and trigger controller fed by the decimating averager.
// Fills a pre-trigger window, waits for a level crossing on the chosen edge,
// then counts post-trigger samples while strobing every sample into the
// capture RAM. All outputs are registered.
// Optional feature: define TRIGGER_AUTO_EN to add the auto_timeout port and a
// forced trigger after auto_timeout samples spent waiting.
module trigger_ctrl
  import trigger_ctrl_pkg::*;
#(
  parameter int BITS_ADC   = BITS_ADC_DEF,
  parameter int BITS_COUNT = BITS_COUNT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BITS_ADC-1:0]   sample_in,
  input  logic                  rdy_in,
  input  logic                  start,
  input  logic [BITS_ADC-1:0]   trig_level,
  input  logic                  trig_falling,
  input  logic [BITS_COUNT-1:0] pretrig,
  input  logic [BITS_COUNT-1:0] num_samples,
`ifdef TRIGGER_AUTO_EN
  input  logic [BITS_COUNT-1:0] auto_timeout,
`endif
  output logic                  wr_en,
  output logic [BITS_ADC-1:0]   sample_out,
  output logic                  busy,
  output logic                  trig_pulse,
  output logic                  triggered,
  output logic                  done
);

  localparam logic [BITS_COUNT-1:0] ONE = BITS_COUNT'(1);

  trig_state_t            state_q, state_d;
  logic [BITS_ADC-1:0]    level_q, level_d;
  logic                   falling_q, falling_d;
  logic [BITS_COUNT-1:0]  pretrig_q, pretrig_d;
  logic [BITS_COUNT-1:0]  num_q, num_d;
  logic [BITS_COUNT-1:0]  pre_cnt_q, pre_cnt_d;
  logic [BITS_COUNT-1:0]  post_cnt_q, post_cnt_d;
  logic [BITS_COUNT-1:0]  post_load;
  logic [BITS_ADC-1:0]    prev_q, prev_d;
  logic                   prev_valid_q, prev_valid_d;
`ifdef TRIGGER_AUTO_EN
  logic [BITS_COUNT-1:0]  timeout_q, timeout_d;
  logic                   forced;
`endif

  logic                   wr_en_d;
  logic [BITS_ADC-1:0]    sample_d;
  logic                   busy_d;
  logic                   trig_pulse_d;
  logic                   triggered_d;
  logic                   done_d;

  logic                   hit;
  logic                   fire;

  edge_detect #(
    .W (BITS_ADC)
  ) u_edge_detect (
    .prev       (prev_q),
    .prev_valid (prev_valid_q),
    .cur        (sample_in),
    .level      (level_q),
    .falling    (falling_q),
    .hit        (hit)
  );

  // Post-trigger count; clamping at start keeps this from wrapping.
  assign post_load = num_q - pretrig_q - ONE;

  // Next-state, counters and registered-output values for this cycle.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    falling_d    = falling_q;
    pretrig_d    = pretrig_q;
    num_d        = num_q;
    pre_cnt_d    = pre_cnt_q;
    post_cnt_d   = post_cnt_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
`ifdef TRIGGER_AUTO_EN
    timeout_d    = timeout_q;
    forced       = 1'b0;
`endif
    wr_en_d      = 1'b0;
    sample_d     = sample_out;
    trig_pulse_d = 1'b0;
    triggered_d  = triggered;
    done_d       = 1'b0;
    fire         = 1'b0;

    if (state_q == TRIG_ST_IDLE) begin
      if (start && (num_samples != '0)) begin
        level_d      = trig_level;
        falling_d    = trig_falling;
        num_d        = num_samples;
        pretrig_d    = (pretrig >= num_samples) ? (num_samples - ONE) : pretrig;
        triggered_d  = 1'b0;
        pre_cnt_d    = '0;
        post_cnt_d   = '0;
        prev_valid_d = 1'b0;
`ifdef TRIGGER_AUTO_EN
        timeout_d    = '0;
`endif
        state_d      = (pretrig_d == '0) ? TRIG_ST_WAIT : TRIG_ST_PRE;
      end
    end else if (rdy_in) begin
      wr_en_d      = 1'b1;
      sample_d     = sample_in;
      prev_d       = sample_in;
      prev_valid_d = 1'b1;
      case (state_q)
        TRIG_ST_PRE: begin
          pre_cnt_d = pre_cnt_q + ONE;
          if (pre_cnt_d == pretrig_q) begin
            state_d = TRIG_ST_WAIT;
`ifdef TRIGGER_AUTO_EN
            timeout_d = '0;
`endif
          end
        end
        TRIG_ST_WAIT: begin
          fire = hit;
`ifdef TRIGGER_AUTO_EN
          timeout_d = timeout_q + ONE;
          forced    = (auto_timeout != '0) && (timeout_d == auto_timeout);
          fire      = hit | forced;
`endif
          if (fire) begin
            trig_pulse_d = 1'b1;
            triggered_d  = triggered | hit;
            post_cnt_d   = post_load;
            if (post_load == '0) begin
              done_d  = 1'b1;
              state_d = TRIG_ST_IDLE;
            end else begin
              state_d = TRIG_ST_POST;
            end
          end
        end
        TRIG_ST_POST: begin
          post_cnt_d = post_cnt_q - ONE;
          if (post_cnt_d == '0) begin
            done_d  = 1'b1;
            state_d = TRIG_ST_IDLE;
          end
        end
        default: begin
          state_d = TRIG_ST_IDLE;
        end
      endcase
    end

    // busy stays up through the done cycle and drops on the following one.
    busy_d = (state_d != TRIG_ST_IDLE) | done_d;
  end

  // State, configuration latches, counters and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= TRIG_ST_IDLE;
      level_q      <= '0;
      falling_q    <= TRIG_EDGE_RISING;
      pretrig_q    <= '0;
      num_q        <= '0;
      pre_cnt_q    <= '0;
      post_cnt_q   <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
`ifdef TRIGGER_AUTO_EN
      timeout_q    <= '0;
`endif
      wr_en        <= 1'b0;
      sample_out   <= '0;
      busy         <= 1'b0;
      trig_pulse   <= 1'b0;
      triggered    <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      falling_q    <= falling_d;
      pretrig_q    <= pretrig_d;
      num_q        <= num_d;
      pre_cnt_q    <= pre_cnt_d;
      post_cnt_q   <= post_cnt_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
`ifdef TRIGGER_AUTO_EN
      timeout_q    <= timeout_d;
`endif
      wr_en        <= wr_en_d;
      sample_out   <= sample_d;
      busy         <= busy_d;
      trig_pulse   <= trig_pulse_d;
      triggered    <= triggered_d;
      done         <= done_d;
    end
  end

endmodule

// File: tb/tb_trigger_ctrl.sv
// Directed testbench for trigger_ctrl. Inputs change 1 ns after each rising
// edge and outputs are observed at the same point, so each observation shows
// the registered response to the inputs of the previous cycle.
// The auto-trigger scenario is included when TRIGGER_AUTO_EN is defined.
module tb_trigger_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  sample_in;
  logic        rdy_in;
  logic        start;
  logic [7:0]  trig_level;
  logic        trig_falling;
  logic [15:0] pretrig;
  logic [15:0] num_samples;
`ifdef TRIGGER_AUTO_EN
  logic [15:0] auto_timeout;
`endif
  logic        wr_en;
  logic [7:0]  sample_out;
  logic        busy;
  logic        trig_pulse;
  logic        triggered;
  logic        done;

  int checks = 0;
  int errors = 0;

  trigger_ctrl #(
    .BITS_ADC   (8),
    .BITS_COUNT (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_in    (sample_in),
    .rdy_in       (rdy_in),
    .start        (start),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .pretrig      (pretrig),
    .num_samples  (num_samples),
`ifdef TRIGGER_AUTO_EN
    .auto_timeout (auto_timeout),
`endif
    .wr_en        (wr_en),
    .sample_out   (sample_out),
    .busy         (busy),
    .trig_pulse   (trig_pulse),
    .triggered    (triggered),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    sample_in = d;
    rdy_in    = 1'b1;
    tick();
    rdy_in    = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] lvl, input logic fall,
                          input logic [15:0] pre, input logic [15:0] num);
    trig_level   = lvl;
    trig_falling = fall;
    pretrig      = pre;
    num_samples  = num;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({wr_en, busy, trig_pulse, triggered, done} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b want 00000",
               {wr_en, busy, trig_pulse, triggered, done});
    end
    checks++;
    if (sample_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL reset_sample_out: got %h want 00", sample_out);
    end
  endtask

  task automatic test_rising();
    logic [7:0] ramp [9];
    ramp = '{8'h70, 8'h78, 8'h7C, 8'h80, 8'h84, 8'h88, 8'h8C, 8'h90, 8'h94};
    do_start(8'h80, 1'b0, 16'd2, 16'd8);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rising_busy_rise: got %b want 1", busy);
    end
    for (int i = 0; i < 9; i++) begin
      send(ramp[i]);
      checks++;
      if (wr_en !== 1'b1 || sample_out !== ramp[i]) begin
        errors++;
        $display("[TB] FAIL rising_write[%0d]: got wr_en=%b data=%h want 1 %h",
                 i, wr_en, sample_out, ramp[i]);
      end
      checks++;
      if (trig_pulse !== (i == 3)) begin
        errors++;
        $display("[TB] FAIL rising_trig[%0d]: got %b want %b", i, trig_pulse, (i == 3));
      end
      checks++;
      if (done !== (i == 8)) begin
        errors++;
        $display("[TB] FAIL rising_done[%0d]: got %b want %b", i, done, (i == 8));
      end
      if (i == 5) begin
        tick();
        checks++;
        if (wr_en !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rising_gap_wr_en: got %b want 0", wr_en);
        end
      end
    end
    checks++;
    if (busy !== 1'b1 || triggered !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rising_done_cycle: got busy=%b triggered=%b want 1 1",
               busy, triggered);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || triggered !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rising_after_done: got busy=%b triggered=%b wr_en=%b want 0 1 0",
               busy, triggered, wr_en);
    end
  endtask

  task automatic test_falling();
    logic [7:0] ramp [5];
    logic [7:0] post [5];
    ramp = '{8'h70, 8'h78, 8'h7C, 8'h80, 8'h84};
    post = '{8'h60, 8'h50, 8'h40, 8'h30, 8'h20};
    do_start(8'h80, 1'b1, 16'd2, 16'd8);
    checks++;
    if (triggered !== 1'b0) begin
      errors++;
      $display("[TB] FAIL falling_triggered_cleared: got %b want 0", triggered);
    end
    for (int i = 0; i < 5; i++) begin
      send(ramp[i]);
      checks++;
      if (trig_pulse !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL falling_ignore_rise[%0d]: got trig=%b busy=%b want 0 1",
                 i, trig_pulse, busy);
      end
    end
    send(8'h90);
    checks++;
    if (trig_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL falling_pre_drop: got %b want 0", trig_pulse);
    end
    send(8'h70);
    checks++;
    if (trig_pulse !== 1'b1 || triggered !== 1'b1 || sample_out !== 8'h70) begin
      errors++;
      $display("[TB] FAIL falling_trig: got trig=%b triggered=%b data=%h want 1 1 70",
               trig_pulse, triggered, sample_out);
    end
    for (int i = 0; i < 5; i++) begin
      send(post[i]);
      checks++;
      if (done !== (i == 4)) begin
        errors++;
        $display("[TB] FAIL falling_done[%0d]: got %b want %b", i, done, (i == 4));
      end
    end
    tick();
  endtask

  task automatic test_clamp();
    logic [7:0] pre [3];
    pre = '{8'h10, 8'h20, 8'h30};
    do_start(8'h80, 1'b0, 16'd10, 16'd4);
    for (int i = 0; i < 3; i++) begin
      send(pre[i]);
      checks++;
      if (wr_en !== 1'b1 || trig_pulse !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL clamp_pre[%0d]: got wr=%b trig=%b done=%b busy=%b want 1 0 0 1",
                 i, wr_en, trig_pulse, done, busy);
      end
    end
    send(8'h90);
    checks++;
    if (trig_pulse !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clamp_trig_done: got trig=%b done=%b want 1 1", trig_pulse, done);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clamp_busy_fall: got %b want 0", busy);
    end
  endtask

  task automatic test_reset_restart();
    do_start(8'h80, 1'b0, 16'd1, 16'd6);
    send(8'h10);
    send(8'h90);
    checks++;
    if (trig_pulse !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_first_trig: got %b want 1", trig_pulse);
    end
    send(8'h91);
    rst       = 1'b1;
    sample_in = 8'h92;
    rdy_in    = 1'b1;
    tick();
    rst       = 1'b0;
    rdy_in    = 1'b0;
    checks++;
    if ({wr_en, busy, trig_pulse, triggered, done} !== 5'b0 || sample_out !== 8'h00) begin
      errors++;
      $display("[TB] FAIL restart_mid_reset: got flags=%b data=%h want 00000 00",
               {wr_en, busy, trig_pulse, triggered, done}, sample_out);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_no_done: got done=%b busy=%b want 0 0", done, busy);
    end
    do_start(8'h80, 1'b0, 16'd0, 16'd3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_busy: got %b want 1", busy);
    end
    send(8'h90);
    checks++;
    if (trig_pulse !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_first_sample_no_trig: got %b want 0", trig_pulse);
    end
    send(8'h10);
    send(8'h85);
    checks++;
    if (trig_pulse !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_trig: got trig=%b done=%b want 1 0", trig_pulse, done);
    end
    send(8'h86);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL restart_early_done: got %b want 0", done);
    end
    send(8'h87);
    checks++;
    if (done !== 1'b1 || triggered !== 1'b1) begin
      errors++;
      $display("[TB] FAIL restart_done: got done=%b triggered=%b want 1 1", done, triggered);
    end
    tick();
  endtask

  task automatic test_ignored_start();
    do_start(8'h80, 1'b0, 16'd2, 16'd5);
    send(8'h10);
    do_start(8'hA0, 1'b1, 16'd0, 16'd2);
    checks++;
    if (busy !== 1'b1 || wr_en !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignored_start_busy: got busy=%b wr=%b want 1 0", busy, wr_en);
    end
    send(8'h12);
    send(8'h90);
    checks++;
    if (trig_pulse !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ignored_start_trig: got %b want 1", trig_pulse);
    end
    send(8'h91);
    send(8'h92);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL ignored_start_done: got %b want 1", done);
    end
    tick();
    do_start(8'h80, 1'b0, 16'd0, 16'd0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_num_busy: got %b want 0", busy);
    end
    send(8'h90);
    checks++;
    if (wr_en !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL zero_num_write: got wr=%b busy=%b want 0 0", wr_en, busy);
    end
  endtask

`ifdef TRIGGER_AUTO_EN
  task automatic test_auto();
    auto_timeout = 16'd5;
    do_start(8'h80, 1'b0, 16'd1, 16'd4);
    send(8'h40);
    for (int i = 0; i < 5; i++) begin
      send(8'h40);
      checks++;
      if (trig_pulse !== (i == 4)) begin
        errors++;
        $display("[TB] FAIL auto_trig[%0d]: got %b want %b", i, trig_pulse, (i == 4));
      end
    end
    checks++;
    if (triggered !== 1'b0) begin
      errors++;
      $display("[TB] FAIL auto_triggered: got %b want 0", triggered);
    end
    send(8'h40);
    send(8'h40);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("[TB] FAIL auto_done: got %b want 1", done);
    end
    tick();
    auto_timeout = 16'd0;
  endtask
`endif

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    sample_in    = 8'h00;
    rdy_in       = 1'b0;
    start        = 1'b0;
    trig_level   = 8'h00;
    trig_falling = 1'b0;
    pretrig      = 16'd0;
    num_samples  = 16'd0;
`ifdef TRIGGER_AUTO_EN
    auto_timeout = 16'd0;
`endif
    test_reset();
    test_rising();
    test_falling();
    test_clamp();
    test_reset_restart();
    test_ignored_start();
`ifdef TRIGGER_AUTO_EN
    test_auto();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
